// File: rtl/plru_pkg.sv
// plru_pkg: shared FSM state type and index-width helpers for the tree-PLRU block.
package plru_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } state_t;

    // Index width for an n-entry table, never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int cnt_w(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/plru_victim_sel.sv
// plru_victim_sel: picks the lowest invalid way, otherwise walks the PLRU tree from the root.
module plru_victim_sel
    import plru_pkg::*;
#(
    parameter int NUM_WAYS = 4,
    localparam int WW = idx_w(NUM_WAYS)
) (
    input  logic [NUM_WAYS-2:0] tree,
    input  logic [NUM_WAYS-1:0] valid,
    output logic [WW-1:0]       way
);

    logic [WW-1:0] walk;
    int            node;

    always_comb begin
        walk = '0;
        node = 0;
        for (int l = 0; l < WW; l++) begin
            walk = (walk << 1) | WW'(tree[node]);
            node = 2 * node + 1 + int'(tree[node]);
        end
        way = walk;
        // Scanning downward lets the lowest invalid way win.
        for (int i = NUM_WAYS - 1; i >= 0; i--) begin
            if (!valid[i]) way = WW'(i);
        end
    end

endmodule

// File: rtl/plru_tree.sv
// plru_tree: per-set tree pseudo-LRU state with registered victim lookup and a one-set-per-cycle flush sweep.
module plru_tree
    import plru_pkg::*;
#(
    parameter int NUM_WAYS = 4,
    parameter int NUM_SETS = 64,
    localparam int WW = idx_w(NUM_WAYS),
    localparam int SW = idx_w(NUM_SETS),
    localparam int CW = cnt_w(NUM_SETS)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                access_i,
    input  logic [SW-1:0]       access_set_i,
    input  logic [NUM_WAYS-1:0] hit_vect_i,
    input  logic                victim_req_i,
    input  logic [SW-1:0]       victim_set_i,
    input  logic [NUM_WAYS-1:0] valid_vect_i,
    output logic [WW-1:0]       victim_o,
    output logic                victim_valid_o,
    input  logic                flush_i,
    output logic                busy_o
);

    logic [NUM_WAYS-2:0] tree [NUM_SETS];
    logic [NUM_WAYS-2:0] upd;
    logic [NUM_WAYS-2:0] sel_tree;
    logic [WW-1:0]       hit_way;
    logic [WW-1:0]       sel;
    logic [CW-1:0]       cnt;
    logic                one_hot;
    logic                acc_ok;
    state_t              state;

    assign busy_o   = (state == FLUSH);
    assign one_hot  = (hit_vect_i != '0) && ((hit_vect_i & (hit_vect_i - 1'b1)) == '0);
    assign acc_ok   = access_i && one_hot && !busy_o;
    // Same-set touch and lookup in one cycle see the post-update bits.
    assign sel_tree = (acc_ok && access_set_i == victim_set_i) ? upd : tree[victim_set_i];

    always_comb begin
        hit_way = '0;
        for (int i = 0; i < NUM_WAYS; i++) begin
            if (hit_vect_i[i]) hit_way = WW'(i);
        end
        upd = tree[access_set_i];
        for (int l = 0; l < WW; l++) begin
            upd[(1 << l) - 1 + int'(hit_way >> (WW - l))] = ~hit_way[WW-1-l];
        end
    end

    plru_victim_sel #(.NUM_WAYS(NUM_WAYS)) u_sel (
        .tree  (sel_tree),
        .valid (valid_vect_i),
        .way   (sel)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state          <= IDLE;
            cnt            <= '0;
            victim_o       <= '0;
            victim_valid_o <= 1'b0;
            for (int s = 0; s < NUM_SETS; s++) tree[s] <= '0;
        end else begin
            victim_o       <= sel;
            victim_valid_o <= victim_req_i && !busy_o;
            if (state == IDLE) begin
                if (acc_ok) tree[access_set_i] <= upd;
                if (flush_i) begin
                    state <= FLUSH;
                    cnt   <= '0;
                end
            end else begin
                tree[cnt[SW-1:0]] <= '0;
                if (cnt == CW'(NUM_SETS - 1)) begin
                    state <= IDLE;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_plru_tree.sv
// tb_plru_tree: directed and random stimulus against a heap-walk PLRU reference model.
module tb_plru_tree;
    import plru_pkg::*;

    localparam int NW = 4;
    localparam int NS = 4;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          access_i = 1'b0;
    logic [1:0]    access_set_i = '0;
    logic [NW-1:0] hit_vect_i = '0;
    logic          victim_req_i = 1'b0;
    logic [1:0]    victim_set_i = '0;
    logic [NW-1:0] valid_vect_i = '1;
    logic [1:0]    victim_o;
    logic          victim_valid_o;
    logic          flush_i = 1'b0;
    logic          busy_o;

    int nvec = 0;
    int nerr = 0;

    int  mt [NS][NW-1];
    bit  mbusy;
    int  mcnt;

    plru_tree #(.NUM_WAYS(NW), .NUM_SETS(NS)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .access_i       (access_i),
        .access_set_i   (access_set_i),
        .hit_vect_i     (hit_vect_i),
        .victim_req_i   (victim_req_i),
        .victim_set_i   (victim_set_i),
        .valid_vect_i   (valid_vect_i),
        .victim_o       (victim_o),
        .victim_valid_o (victim_valid_o),
        .flush_i        (flush_i),
        .busy_o         (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input int got, input int exp);
        nvec++;
        if (got != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void m_clear();
        for (int s = 0; s < NS; s++)
            for (int n = 0; n < NW - 1; n++) mt[s][n] = 0;
        mbusy = 0;
        mcnt  = 0;
    endfunction

    // Climb from the leaf, pointing each ancestor at the sibling subtree.
    function automatic void m_touch(input int s, input int w);
        int n, p;
        n = w + NW - 1;
        while (n > 0) begin
            p = (n - 1) / 2;
            mt[s][p] = (n == 2 * p + 1) ? 1 : 0;
            n = p;
        end
    endfunction

    function automatic int m_victim(input int s, input logic [NW-1:0] vld);
        int n;
        for (int i = 0; i < NW; i++) if (!vld[i]) return i;
        n = 0;
        while (n < NW - 1) n = mt[s][n] ? 2 * n + 2 : 2 * n + 1;
        return n - (NW - 1);
    endfunction

    task automatic step(input bit acc, input int aset, input logic [NW-1:0] hit,
                        input bit req, input int vset, input logic [NW-1:0] vld, input bit fl);
        int exp_v;
        bit exp_vv;
        access_i = acc; access_set_i = 2'(aset); hit_vect_i = hit;
        victim_req_i = req; victim_set_i = 2'(vset); valid_vect_i = vld; flush_i = fl;
        exp_vv = req && !mbusy;
        if (!mbusy && acc && $countones(hit) == 1)
            for (int i = 0; i < NW; i++) if (hit[i]) m_touch(aset, i);
        exp_v = m_victim(vset, vld);
        if (mbusy) begin
            for (int n = 0; n < NW - 1; n++) mt[mcnt][n] = 0;
            mcnt++;
            if (mcnt == NS) mbusy = 0;
        end else if (fl) begin
            mbusy = 1;
            mcnt  = 0;
        end
        @(posedge clk_i);
        #1;
        access_i = 0; victim_req_i = 0; flush_i = 0; hit_vect_i = '0; valid_vect_i = '1;
        check("victim_valid", int'(victim_valid_o), int'(exp_vv));
        if (exp_vv) check("victim", int'(victim_o), exp_v);
        check("busy", int'(busy_o), int'(mbusy));
    endtask

    task automatic touch(input int s, input int w);
        step(1, s, NW'(1 << w), 0, 0, '1, 0);
    endtask

    task automatic req(input int s);
        step(0, 0, '0, 1, s, '1, 0);
    endtask

    task automatic do_reset();
        rst_i = 1;
        #1;
        check("rst_busy", int'(busy_o), 0);
        check("rst_valid", int'(victim_valid_o), 0);
        check("rst_victim", int'(victim_o), 0);
        m_clear();
        @(posedge clk_i);
        #1;
        rst_i = 0;
    endtask

    initial begin
        m_clear();
        #2;
        do_reset();

        req(0);
        check("first_victim", int'(victim_o), 0);
        step(0, 0, '0, 0, 0, '1, 0);

        for (int w = 0; w < NW; w++) touch(0, w);
        req(0);
        check("lru_after_all", int'(victim_o), 0);
        do_reset();
        touch(0, 0);
        req(0);
        check("after_way0", int'(victim_o), 2);

        step(0, 0, '0, 1, 0, 4'b1011, 0);
        check("invalid_way", int'(victim_o), 2);
        touch(0, 2);
        step(0, 0, '0, 1, 0, 4'b1011, 0);
        check("invalid_way2", int'(victim_o), 2);

        do_reset();
        step(1, 1, 4'b0001, 1, 1, '1, 0);
        check("bypass", int'(victim_o), 2);
        req(0);
        check("other_set", int'(victim_o), 0);

        for (int s = 0; s < NS; s++) touch(s, s);
        step(0, 0, '0, 0, 0, '1, 1);
        for (int c = 0; c < NS; c++) step(1, c, 4'b0100, 1, c, '1, c == 1);
        for (int s = 0; s < NS; s++) begin
            req(s);
            check("post_flush", int'(victim_o), 0);
        end

        for (int s = 0; s < NS; s++) touch(s, 1);
        step(0, 0, '0, 0, 0, '1, 1);
        step(0, 0, '0, 0, 0, '1, 0);
        step(0, 0, '0, 0, 0, '1, 0);
        #2;
        do_reset();
        for (int s = 0; s < NS; s++) begin
            req(s);
            check("post_abort", int'(victim_o), 0);
        end
        step(1, 0, 4'b0011, 0, 0, '1, 0);
        req(0);
        check("multi_hot", int'(victim_o), 0);

        for (int k = 0; k < 400; k++) begin
            logic [NW-1:0] h, v;
            h = ($urandom_range(0, 5) == 0) ? NW'($urandom) : NW'(1 << $urandom_range(0, NW - 1));
            v = ($urandom_range(0, 3) == 0) ? NW'($urandom) : '1;
            step(bit'($urandom), $urandom_range(0, NS - 1), h, bit'($urandom),
                 $urandom_range(0, NS - 1), v, $urandom_range(0, 40) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
